// File: rtl/alu_operand_sequencer_if.sv
// Bundle of the handshake, operand and logic-unit bus signals around the
// operand sequencer. The master side is the control unit / operand bus /
// logic unit environment; the slave side is the sequencer itself.
interface alu_operand_sequencer_if;
  // control-unit handshake
  logic       start;
  logic [1:0] op;
  logic       busy;
  logic       done;
  logic       error;
  // operand bus
  logic [7:0] data_in;
  logic       data_valid;
  // logic-unit connection
  logic [7:0] result_bus;
  logic [3:0] flags_bus;
  logic [7:0] primary_operand;
  logic [7:0] secondary_operand;
  logic       and_or;
  logic       logic_oe;
  // captured results
  logic [7:0] result;
  logic [3:0] flags;

  modport master (
    output start, op, data_in, data_valid, result_bus, flags_bus,
    input  busy, done, error, primary_operand, secondary_operand,
           and_or, logic_oe, result, flags
  );

  modport slave (
    input  start, op, data_in, data_valid, result_bus, flags_bus,
    output busy, done, error, primary_operand, secondary_operand,
           and_or, logic_oe, result, flags
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the 8-bit bitwise logic unit. Collects two operand
// bytes from the operand bus, presents them with the AND/OR select, opens the
// logic unit's tri-state drivers for exactly one cycle and captures the
// result and flags. All outputs are registered.
module alu_operand_sequencer (
  input  logic                          clock,
  input  logic                          nreset,
  alu_operand_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    EXEC    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t     state_reg;
  logic [7:0] primary_reg;
  logic [7:0] secondary_reg;
  logic       and_or_reg;
  logic       logic_oe_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       error_reg;
  logic [7:0] result_reg;
  logic [3:0] flags_reg;

  // Sequencer FSM with all outputs registered; done/error default low so they
  // pulse for a single cycle.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_reg     <= IDLE;
      primary_reg   <= 8'h00;
      secondary_reg <= 8'h00;
      and_or_reg    <= 1'b0;
      logic_oe_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      result_reg    <= 8'h00;
      flags_reg     <= 4'h0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (!bus.op[1]) begin
              // op 00 is AND (select 1), op 01 is OR (select 0)
              and_or_reg <= ~bus.op[0];
              busy_reg   <= 1'b1;
              state_reg  <= LOAD_A;
            end else begin
              error_reg <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (bus.data_valid) begin
            primary_reg <= bus.data_in;
            state_reg   <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (bus.data_valid) begin
            secondary_reg <= bus.data_in;
            state_reg     <= EXEC;
          end
        end
        EXEC: begin
          // logic unit registers its result at the end of this cycle, so the
          // drivers are opened for the following cycle only
          logic_oe_reg <= 1'b1;
          state_reg    <= CAPTURE;
        end
        CAPTURE: begin
          result_reg   <= bus.result_bus;
          flags_reg    <= bus.flags_bus;
          logic_oe_reg <= 1'b0;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.primary_operand   = primary_reg;
  assign bus.secondary_operand = secondary_reg;
  assign bus.and_or            = and_or_reg;
  assign bus.logic_oe          = logic_oe_reg;
  assign bus.busy              = busy_reg;
  assign bus.done              = done_reg;
  assign bus.error             = error_reg;
  assign bus.result            = result_reg;
  assign bus.flags             = flags_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed testbench for alu_operand_sequencer with a small behavioural
// logic unit attached to the operand/result buses.
module tb_alu_operand_sequencer;

  logic clock;
  logic nreset;
  int   checks;
  int   errors;

  alu_operand_sequencer_if bus ();

  alu_operand_sequencer dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural logic unit: registers its result every edge and only drives
  // the buses while enabled; otherwise the bus carries a junk pattern.
  logic [7:0] lu_result_reg;
  always @(posedge clock)
    lu_result_reg <= bus.and_or ? (bus.primary_operand & bus.secondary_operand)
                                : (bus.primary_operand | bus.secondary_operand);
  assign bus.result_bus = bus.logic_oe ? lu_result_reg : 8'hEE;
  assign bus.flags_bus  = bus.logic_oe ? {2'b10, lu_result_reg[7], lu_result_reg == 8'h00} : 4'h5;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one operation: start before edge 0, operand A at edge 1, operand B
  // gap_b cycles later. Returns at the done cycle or after a cycle bound.
  task automatic drive_op(input logic [1:0] op_v, input logic [7:0] a, input logic [7:0] b,
                          input int gap_b, input bit hold_start,
                          output int done_cyc, output int oe_cyc, output int oe_cnt,
                          output int busy_cnt, output logic and_or_seen);
    done_cyc = 0; oe_cyc = 0; oe_cnt = 0; busy_cnt = 0; and_or_seen = 1'bx;
    bus.start = 1'b1;
    bus.op    = op_v;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      tick();
      if (!hold_start) bus.start = 1'b0;
      bus.data_valid = (cyc == 1) || (cyc == 2 + gap_b);
      bus.data_in    = (cyc == 1) ? a : ((cyc == 2 + gap_b) ? b : 8'hAA);
      if (bus.logic_oe) begin oe_cnt++; oe_cyc = cyc; end
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cyc = cyc;
      if (cyc == 3 + gap_b) and_or_seen = bus.and_or;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] all_out;
    nreset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.data_in = 8'h00; bus.data_valid = 1'b0;
    tick(); tick();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      all_out = {bus.primary_operand, bus.secondary_operand, bus.and_or, bus.logic_oe,
                 bus.busy, bus.done, bus.error, bus.result, bus.flags, 3'b000};
      checks++;
      if (all_out !== 38'h0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h expected 0", i, all_out);
      end
    end
  endtask

  task automatic test_and_path();
    int d, oc, on, bc; logic ao;
    drive_op(2'b00, 8'hF0, 8'h3C, 0, 1'b0, d, oc, on, bc, ao);
    checks++; if (d !== 5)  begin errors++; $display("FAIL and_done_cycle: got %0d expected 5", d); end
    checks++; if (ao !== 1'b1) begin errors++; $display("FAIL and_select: got %b expected 1", ao); end
    checks++; if (oc !== 4 || on !== 1) begin errors++; $display("FAIL and_oe: cycle %0d count %0d expected cycle 4 count 1", oc, on); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL and_busy_cycles: got %0d expected 4", bc); end
    checks++; if (bus.result !== 8'h30) begin errors++; $display("FAIL and_result: got %h expected 30", bus.result); end
    checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL and_flags: got %b expected 1000", bus.flags); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.logic_oe !== 1'b0 || bus.result !== 8'h30)
      begin errors++; $display("FAIL and_after_done: done=%b oe=%b result=%h expected 0 0 30", bus.done, bus.logic_oe, bus.result); end
  endtask

  task automatic test_or_gap();
    int d, oc, on, bc; logic ao;
    drive_op(2'b01, 8'h80, 8'h01, 2, 1'b0, d, oc, on, bc, ao);
    checks++; if (d !== 7) begin errors++; $display("FAIL or_done_cycle: got %0d expected 7", d); end
    checks++; if (ao !== 1'b0) begin errors++; $display("FAIL or_select: got %b expected 0", ao); end
    checks++; if (oc !== 6 || on !== 1) begin errors++; $display("FAIL or_oe: cycle %0d count %0d expected cycle 6 count 1", oc, on); end
    checks++; if (bc !== 6) begin errors++; $display("FAIL or_busy_cycles: got %0d expected 6", bc); end
    checks++; if (bus.result !== 8'h81) begin errors++; $display("FAIL or_result: got %h expected 81", bus.result); end
    checks++; if (bus.flags !== 4'b1010) begin errors++; $display("FAIL or_flags: got %b expected 1010", bus.flags); end
    tick();
  endtask

  task automatic test_reserved_op();
    int dn, bz, oe;
    bus.start = 1'b1; bus.op = 2'b10;
    tick();
    bus.start = 1'b0; bus.data_valid = 1'b1; bus.data_in = 8'h55;
    checks++; if (bus.error !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reserved_error: error=%b busy=%b expected 1 0", bus.error, bus.busy); end
    dn = 0; bz = 0; oe = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.data_in = 8'h66;
      if (i == 1) bus.data_valid = 1'b0;
      if (bus.done) dn++;
      if (bus.busy) bz++;
      if (bus.logic_oe || bus.error) oe++;
    end
    checks++; if (dn !== 0 || bz !== 0 || oe !== 0)
      begin errors++; $display("FAIL reserved_quiet: done=%0d busy=%0d oe_or_err=%0d expected 0 0 0", dn, bz, oe); end
    checks++; if (bus.primary_operand !== 8'h80 || bus.result !== 8'h81)
      begin errors++; $display("FAIL reserved_hold: a=%h result=%h expected 80 81", bus.primary_operand, bus.result); end
    bus.start = 1'b1; bus.op = 2'b11;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.error !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reserved11_error: error=%b busy=%b expected 1 0", bus.error, bus.busy); end
    tick();
    checks++; if (bus.error !== 1'b0)
      begin errors++; $display("FAIL reserved11_pulse: error=%b expected 0", bus.error); end
  endtask

  task automatic test_start_held();
    int d, oc, on, bc; logic ao;
    drive_op(2'b00, 8'h12, 8'h34, 0, 1'b1, d, oc, on, bc, ao);
    checks++; if (d !== 5 || bus.result !== 8'h10 || bus.flags !== 4'b1000)
      begin errors++; $display("FAIL held_first: done=%0d result=%h flags=%b expected 5 10 1000", d, bus.result, bus.flags); end
    tick();  // cycle 6: back in IDLE, start still high
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL held_gap: busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    tick();  // cycle 7: second operation accepted at edge 6
    bus.start = 1'b0; bus.data_valid = 1'b1; bus.data_in = 8'h00;
    checks++; if (bus.busy !== 1'b1)
      begin errors++; $display("FAIL held_second_start: busy=%b expected 1", bus.busy); end
    tick();  // cycle 8
    tick();  // cycle 9
    bus.data_valid = 1'b0;
    tick();  // cycle 10
    tick();  // cycle 11
    checks++; if (bus.done !== 1'b1 || bus.result !== 8'h00 || bus.flags !== 4'b1001)
      begin errors++; $display("FAIL held_second_done: done=%b result=%h flags=%b expected 1 00 1001", bus.done, bus.result, bus.flags); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int d, oc, on, bc; logic ao;
    bus.start = 1'b1; bus.op = 2'b01;
    tick();
    bus.start = 1'b0; bus.data_valid = 1'b1; bus.data_in = 8'h0F;
    tick();
    bus.data_in = 8'hF0;
    tick();
    bus.data_valid = 1'b0;
    tick();  // cycle 4: CAPTURE
    checks++; if (bus.logic_oe !== 1'b1)
      begin errors++; $display("FAIL midrst_capture_oe: got %b expected 1", bus.logic_oe); end
    nreset = 1'b0;
    tick();
    checks++; if (bus.logic_oe !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 ||
                  bus.result !== 8'h00 || bus.flags !== 4'h0 || bus.primary_operand !== 8'h00)
      begin errors++; $display("FAIL midrst_state: oe=%b done=%b busy=%b result=%h flags=%b a=%h expected 0 0 0 00 0000 00",
                               bus.logic_oe, bus.done, bus.busy, bus.result, bus.flags, bus.primary_operand); end
    nreset = 1'b1;
    tick();
    checks++; if (bus.done !== 1'b0)
      begin errors++; $display("FAIL midrst_no_done: got %b expected 0", bus.done); end
    drive_op(2'b00, 8'hFF, 8'h81, 0, 1'b0, d, oc, on, bc, ao);
    checks++; if (d !== 5 || bus.result !== 8'h81 || bus.flags !== 4'b1010)
      begin errors++; $display("FAIL midrst_recover: done=%0d result=%h flags=%b expected 5 81 1010", d, bus.result, bus.flags); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_and_path();
    test_or_gap();
    test_reserved_op();
    test_start_held();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Sequencer sitting directly upstream of the bitwise logic unit in the 8-bit datapath. It collects the primary and secondary operands from the shared 8-bit operand bus and drives them, with the AND/OR select, into the logic unit. It then enables the logic unit's tri-state result/flag drivers and captures the result and flags into local registers. A start/busy/done handshake links it to the control unit.

## Interface
- No parameters; datapath width fixed at 8 bits, flag width at 4 bits.
- clock  in  1  system clock, all state changes on rising edge
- nreset  in  1  reset, synchronous, active-low; clock clock
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  operation: 00 AND, 01 OR, 10/11 reserved
- data_in  in  8  operand byte from operand bus
- data_valid  in  1  data_in holds a valid operand byte this cycle
- result_bus  in  8  tri-state result bus driven by the logic unit
- flags_bus  in  4  tri-state flag bus driven by the logic unit ([0] zero, [1] negative, [3:2] unused)
- primary_operand  out  8  operand A to the logic unit, registered
- secondary_operand  out  8  operand B to the logic unit, registered
- and_or  out  1  1 = AND, 0 = OR, registered
- logic_oe  out  1  output enable to the logic unit, registered
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result/flags valid
- error  out  1  one-cycle pulse; reserved op rejected
- result  out  8  captured result, held until the next done
- flags  out  4  captured flags, held until the next done

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, DONE.
- IDLE, start=1, op in {00,01}:
  - latch and_or = ~op[0];
  - go to LOAD_A; busy=1.
- IDLE, start=1, op in {10,11}: error=1 for one cycle, remain IDLE, busy stays 0.
- LOAD_A: on data_valid=1, primary_operand <= data_in, go to LOAD_B; otherwise wait indefinitely.
- LOAD_B: on data_valid=1, secondary_operand <= data_in, go to EXEC; otherwise wait.
- EXEC: operands and and_or stable; the logic unit registers its result at the end of this cycle; go to CAPTURE; logic_oe <= 1 on this edge.
- CAPTURE: logic_oe=1 for exactly this cycle; at its end:
  - result <= result_bus, flags <= flags_bus;
  - logic_oe <= 0, done <= 1;
  - go to DONE.
- DONE: done=1, busy=0. Go to IDLE. start in DONE is ignored.
- start is ignored in all states except IDLE. data_valid outside LOAD_A/LOAD_B is ignored.
- Operands, and_or, result and flags hold their values until overwritten; no bus value is captured except in CAPTURE.
- flags are captured bit-for-bit; no flag is recomputed locally.

## Timing
- Reset values (any state, including mid-operation):
  - state IDLE;
  - primary_operand=0, secondary_operand=0;
  - and_or=0, logic_oe=0;
  - busy=0, done=0, error=0;
  - result=0, flags=0.
- Reset takes effect on the first rising edge with nreset=0. logic_oe is guaranteed low from that edge, so the tri-state bus is released within one cycle.
- Minimum latency, with start at edge 0 and data_valid at edges 1 and 2:
  - EXEC in cycle 3;
  - CAPTURE (logic_oe=1) in cycle 4;
  - done=1 with result/flags valid in cycle 5.
- Total: 5 cycles start-to-done.
- busy rises the cycle after start is accepted and falls in the done cycle. A new start is accepted the cycle after done.
- Back-to-back data_valid in LOAD_A and LOAD_B is allowed. Each wait cycle adds one cycle of latency.
- logic_oe is never high for more than one cycle per operation and never high outside CAPTURE.

## Test plan
- Reset, then idle 3 cycles: all outputs 0, logic_oe never high.
- AND path: start op=00, data 0xF0 then 0x3C, logic unit attached:
  - and_or=1;
  - logic_oe high only in cycle 4;
  - done in cycle 5, result=0x30, flags[1:0]=00.
- OR path with a gap: op=01, data 0x80, two idle cycles, then 0x01:
  - result=0x81, flags[1]=1;
  - done in cycle 7.
- Reserved op=10 with start: error pulse the next cycle, busy stays 0, no LOAD_A entry, result unchanged.
- start held high through a full operation: exactly one done; a second operation begins only in the cycle after done.
- nreset=0 asserted during CAPTURE: next edge logic_oe=0, state IDLE, result=0, no done pulse. A new operation then completes normally.
